// File: rtl/rng_scheduler.sv
// rng_scheduler: round-robin arbiter sharing one LFSR among NUM_REQ agents.
// A grant holds the LFSR Enable for SETTLE cycles so a fresh sample clears
// the LFSR output synchronizer, then the sample is returned to the owner
// with a one-cycle rand_valid strobe.
// Optional feature macro: RNG_SCHED_REJECT_EN
//   defined   -> per-agent exclusive upper bound via rejection sampling,
//                up to MAX_RETRY redraws, then a fallback value of 0
//   undefined -> limit is ignored and every sample is accepted
module rng_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 9,
  parameter int SETTLE    = 2,
  parameter int MAX_RETRY = 3
) (
  input  logic                       Clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   limit,
  input  logic [WIDTH-1:0]           rng_in,
  output logic                       rng_enable,
  output logic [NUM_REQ-1:0]         grant,
  output logic [WIDTH-1:0]           rand_out,
  output logic                       rand_valid
);

  localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAW,
    S_CHECK,
    S_DONE
  } state_t;

  state_t               r_state;
  logic [NUM_REQ-1:0]   r_grant;
  logic [PTR_W-1:0]     r_idx;
  logic [PTR_W-1:0]     r_ptr;
  logic [CNT_W-1:0]     r_cnt;
  logic [WIDTH-1:0]     r_rand;

  logic                 w_any;
  logic [PTR_W-1:0]     w_pick;
  logic [NUM_REQ-1:0]   w_pick_oh;
  logic [PTR_W-1:0]     w_next_ptr;
  logic                 w_own_req;
  logic                 w_accept;

`ifdef RNG_SCHED_REJECT_EN
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY);

  logic [RETRY_W-1:0]   r_retry;
  logic [WIDTH-1:0]     w_limit;

  // Bound of the current owner; grant is one-hot so at most one slice hits.
  always_comb begin
    w_limit = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (r_grant[i]) begin
        w_limit = limit[i*WIDTH +: WIDTH];
      end
    end
  end

  // A zero bound means unbounded; otherwise exclusive unsigned upper bound.
  always_comb begin
    w_accept = (w_limit == '0) || (rng_in < w_limit);
  end
`else
  logic w_limit_unused;

  assign w_limit_unused = ^limit;

  // Without range limiting every sample is taken as drawn.
  always_comb begin
    w_accept = 1'b1;
  end
`endif

  // Round-robin pick: first pending request at or after r_ptr, wrapping.
  always_comb begin
    w_any     = 1'b0;
    w_pick    = '0;
    w_pick_oh = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!w_any && req[i] && (i == ((32'(r_ptr) + k) % NUM_REQ))) begin
          w_any        = 1'b1;
          w_pick       = i[PTR_W-1:0];
          w_pick_oh[i] = 1'b1;
        end
      end
    end
  end

  // Pointer moves just past the index that was served or aborted.
  always_comb begin
    w_next_ptr = (r_idx == PTR_LAST) ? '0 : r_idx + 1'b1;
    w_own_req  = |(req & r_grant);
  end

  // Draw sequencing; an owner dropping its request aborts DRAW/CHECK.
  always_ff @(posedge Clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_idx   <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_rand  <= '0;
`ifdef RNG_SCHED_REJECT_EN
      r_retry <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant <= w_pick_oh;
            r_idx   <= w_pick;
            r_cnt   <= '0;
`ifdef RNG_SCHED_REJECT_EN
            r_retry <= '0;
`endif
            r_state <= S_DRAW;
          end
        end
        S_DRAW: begin
          if (!w_own_req) begin
            r_ptr   <= w_next_ptr;
            r_grant <= '0;
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_state <= S_CHECK;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
          end
        end
        S_CHECK: begin
          if (!w_own_req) begin
            r_ptr   <= w_next_ptr;
            r_grant <= '0;
            r_state <= S_IDLE;
          end else if (w_accept) begin
            r_rand  <= rng_in;
            r_state <= S_DONE;
          end
`ifdef RNG_SCHED_REJECT_EN
          else if (r_retry != RETRY_LAST) begin
            r_retry <= r_retry + 1'b1;
            r_state <= S_DRAW;
          end else begin
            r_rand  <= '0;
            r_state <= S_DONE;
          end
`endif
        end
        S_DONE: begin
          r_ptr   <= w_next_ptr;
          r_grant <= '0;
          r_state <= S_IDLE;
        end
        default: begin
          r_grant <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign rng_enable = (r_state == S_DRAW);
  assign rand_valid = (r_state == S_DONE);
  assign grant      = r_grant;
  assign rand_out   = r_rand;

endmodule

// File: doc/rng_scheduler.md
# rng_scheduler

Round-robin scheduler that shares the single 9-bit LFSR random source among up to NUM_REQ game agents (enemy tank AI, spawn-point picker, power-up placer). It arbitrates requests and pulses the LFSR `Enable` long enough for a fresh sample to pass its two-stage output synchronizer. It can range-limit each draw by rejection sampling, then returns the value to the granted requester with a one-cycle valid strobe. It sits between the LFSR instance and the game-logic FSMs.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 9, random value width; must equal the LFSR output width
- SETTLE, 2, cycles `rng_enable` is held per draw (LFSR output pipeline depth)
- MAX_RETRY, 3, extra draws allowed after a rejected sample

Ports:
- Clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req  in  NUM_REQ  level request per agent; held until `rand_valid`
- limit  in  NUM_REQ*WIDTH  packed exclusive upper bound per agent, slice i = limit[i*WIDTH +: WIDTH]; 0 = unbounded
- rng_in  in  WIDTH  LFSR output
- rng_enable  out  1  LFSR Enable
- grant  out  NUM_REQ  one-hot owner of current draw, 0 when idle
- rand_out  out  WIDTH  drawn value, valid when `rand_valid`
- rand_valid  out  1  one-cycle strobe to `grant` owner

## Operation
- States: IDLE, DRAW, CHECK, DONE.
- IDLE: if |req, register grant = first set bit at or after rr_ptr (wrapping), clear retry_cnt, go DRAW; else stay.
- DRAW: rng_enable=1; stay SETTLE cycles (counter), then go CHECK.
- CHECK: sample rng_in. Accept if limit_i==0 or rng_in<limit_i (unsigned compare). Accept: rand_out<=rng_in, go DONE. Reject with retry_cnt<MAX_RETRY: retry_cnt++, go DRAW. Reject with retry_cnt==MAX_RETRY: rand_out<=0, go DONE.
- DONE: rand_valid=1 for one cycle. rr_ptr <= granted index+1 mod NUM_REQ. Clear grant. Go IDLE.
- Abort: if granted req bit is 0 in DRAW or CHECK, go IDLE next cycle. No rand_valid; grant cleared; rr_ptr advances past aborted index.
- Requests arriving mid-draw wait; no preemption. Non-granted req changes are ignored until IDLE.
- rng_enable, rand_valid: Moore decodes of state; grant, rand_out: registers.
- reset (any state): state IDLE, grant 0, rand_out 0, rand_valid 0, rng_enable 0, rr_ptr 0, retry_cnt 0, settle counter 0.

## Timing
- Edge E0 in IDLE with |req: grant visible after E0.
- rng_enable high for SETTLE cycles after E0. CHECK follows. rand_valid is high in the cycle after E(SETTLE+1).
- Accept on first draw: rand_valid asserted SETTLE+2 cycles after E0 (4 at default).
- Each reject adds SETTLE+1 cycles. Worst case is SETTLE+2+MAX_RETRY*(SETTLE+1) = 13 at default.
- After DONE, IDLE takes one cycle. Back-to-back draws therefore start every SETTLE+3 cycles minimum.
- Single-requester NUM_REQ=1: rr_ptr stays 0.

## Configuration
- RNG_SCHED_REJECT_EN defined: limit-based rejection sampling and fallback as above.
- Undefined: `limit` ignored, CHECK always accepts, retry_cnt logic removed; latency fixed at SETTLE+2.

## Test plan
- Single req[0], limit 0. Bench LFSR model presents 0x1A5 once rng_enable drops. Required: grant=0001, rng_enable high exactly 2 cycles, rand_valid 4 cycles after E0 with rand_out=0x1A5.
- req=1111 held, limits 0. Required: grant sequence 0001,0010,0100,1000,0001 with one rand_valid each, spaced 5 cycles.
- req[2] with limit 100 and scripted samples 300, 500, 20. Required: two rejects, rand_out=20, rand_valid 10 cycles after E0.
- req[1] with limit 1 and samples all ≥1. Required: 4 draws, rand_out=0, rand_valid at cycle 13.
- req[3] deasserted during second DRAW cycle, req[0] pending. Required: no rand_valid; IDLE next cycle; then grant=0001 (rr_ptr wrapped past 3).
- reset asserted in CHECK. Required: next cycle all outputs 0 and state IDLE. A later req[1] is granted first, since rr_ptr=0 and it is the lowest pending.
